fx_slave_regs: RTL and testbench
================================

# fx_slave_regs

Responder on the fx bus driven by the command master on the serial link. It decodes 22-bit fx addresses (6-bit device field, 16-bit register offset), serves single-byte writes and reads for one device ID, and exposes a configuration register bank, status, a command-pulse register and a local-to-host byte FIFO. Instances sit next to each processing block; their fx_q outputs are OR-combined back to the master.

## Interface
- DEV_ID, 6'h01: device field this instance answers to.
- VERSION, 8'h10: value of the read-only version register.
- FIFO_DEPTH, 16: FIFO entries, power of two, 2..256.
- clk_sys  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- fx_wr  in  1  one-cycle write strobe.
- fx_waddr  in  22  write address, {dev[5:0], reg[15:0]}.
- fx_data  in  8  write data, valid with fx_wr.
- fx_rd  in  1  one-cycle read strobe.
- fx_raddr  in  22  read address, valid with fx_rd.
- fx_q  out  8  read data; 0x00 except the cycle after a matched read.
- cfg_regs  out  128  config bytes 0..15; byte n at [8n+7:8n].
- cmd_pulse  out  8  one-cycle pulse vector.
- in_data  in  8  local FIFO push data.
- in_vld  in  1  local FIFO push strobe.
- irq  out  1  level: FIFO not empty or overflow flag set.

## Operation
- Match: an access is served only if the addr[21:16] field equals DEV_ID. Unmatched accesses cause no state change, and fx_q stays 0x00.
- Register map (offset, access, content):
  - 0x0000–0x000F RW: config bytes, reset 0x00.
  - 0x0010 RO: DEV_ID, zero-extended.
  - 0x0011 RO: VERSION.
  - 0x0012 status: bit0 empty, bit1 full, bit2 overflow (sticky, write 1 to clear), other bits 0.
  - 0x0013 RO: FIFO level, saturating at 0xFF.
  - 0x0014 RO: FIFO data; a read pops one entry.
  - 0x0015 WO: a write puts fx_data on cmd_pulse for one cycle; reads return 0x00.
  - All other offsets read 0x00 and ignore writes.
- FIFO push: a push with in_vld while the FIFO is not full is accepted.
- FIFO full: a push while full is dropped and the overflow bit is set.
- Push and pop in the same cycle:
  - Both are accepted when the FIFO is full.
  - When empty, the pop returns 0x00 and the push is stored.
- Pop when empty: returns 0x00; pointers unchanged.
- Pointers wrap modulo FIFO_DEPTH. The level is kept in log2(FIFO_DEPTH)+1 bits.
- fx_wr and fx_rd in the same cycle: the read returns the pre-write value and the write takes effect.
- Overflow set and W1C in the same cycle: the set wins.

## Timing
- Read latency 1 cycle: fx_rd in cycle N gives fx_q valid in cycle N+1 only, back to 0x00 in cycle N+2.
- Write latency 1 cycle: fx_wr in cycle N makes the register value visible on cfg_regs, and to reads, from cycle N+1.
- cmd_pulse is high in cycle N+1 only. Consecutive writes give consecutive pulses.
- Pop on read of 0x0014: data returned in N+1; level decremented in N+1.
- Push: in_vld in cycle N makes the level and irq update in N+1.
- Reset (async assert, synchronous-release by the system reset tree) clears:
  - fx_q, cmd_pulse, all config bytes and the overflow flag to 0.
  - FIFO pointers to 0; irq 0.
- Reset mid-transfer drops the transfer; no partial state survives.

## Configuration
- FX_SLAVE_FIFO_EN defined: FIFO, level, data-pop register, status bits 0–2 and the FIFO/overflow terms of irq are present.
- FX_SLAVE_FIFO_EN undefined:
  - No FIFO storage is built.
  - 0x0012–0x0014 read 0x00 and ignore writes.
  - in_data and in_vld are ignored; irq is tied to 0.
  - Ports are unchanged.

## Structure
- Shared package fx_pkg holds:
  - Field widths: FX_ADDR_W=22, FX_DEV_W=6, FX_REG_W=16, FX_DATA_W=8.
  - Register offset constants REG_CFG0, REG_ID, REG_VER, REG_STAT, REG_LVL, REG_FIFO, REG_PULSE.
  - Status bit indices.
- One sub-module, fx_slave_fifo: synchronous single-clock FIFO with push/pop/full/empty/level/overflow. It is instantiated only under FX_SLAVE_FIFO_EN.

## Test plan
- Write 0x5A to {DEV_ID,0x0003}, then read it → cfg_regs[31:24]=0x5A from the next cycle; read gives fx_q=0x5A for exactly one cycle.
- Read {DEV_ID+1,0x0010} → fx_q stays 0x00. Write to the same device → cfg_regs unchanged.
- Read 0x0010 and 0x0011 → 0x01 and 0x10. Write 0xA5 to 0x0015 → cmd_pulse=0xA5 for one cycle.
- Push 0x11, 0x22, 0x33 → level reads 3 and irq=1. Three reads of 0x0014 → 0x11, 0x22, 0x33. Fourth read → 0x00; status=0x01; irq=0.
- Push 17 bytes into a 16-deep FIFO → status=0x06 (full + overflow), level 16.
  - Write 0x04 to status → overflow clears.
  - Simultaneous push and pop while full → level stays 16.
- Assert rst mid-stream with the FIFO partially full and cfg set → all outputs 0 and level 0. Repeat the FIFO scenarios with FX_SLAVE_FIFO_EN undefined → 0x0012–0x0014 read 0x00 and irq stays 0.

Source files
------------

// File: rtl/fx_pkg.sv
//------------------------------------------------------------------------------
// fx_pkg
// Shared fx bus field widths, slave register offsets and status bit indices.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fx_pkg;

  // fx address = {device[5:0], register[15:0]}
  localparam int FX_ADDR_W = 22;
  localparam int FX_DEV_W  = 6;
  localparam int FX_REG_W  = 16;
  localparam int FX_DATA_W = 8;

  // Number of configuration bytes exposed on cfg_regs
  localparam int FX_NUM_CFG = 16;

  // Register offsets
  localparam logic [FX_REG_W-1:0] REG_CFG0  = 16'h0000;
  localparam logic [FX_REG_W-1:0] REG_ID    = 16'h0010;
  localparam logic [FX_REG_W-1:0] REG_VER   = 16'h0011;
  localparam logic [FX_REG_W-1:0] REG_STAT  = 16'h0012;
  localparam logic [FX_REG_W-1:0] REG_LVL   = 16'h0013;
  localparam logic [FX_REG_W-1:0] REG_FIFO  = 16'h0014;
  localparam logic [FX_REG_W-1:0] REG_PULSE = 16'h0015;

  // Status register bit positions
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;

endpackage : fx_pkg

`default_nettype wire

// File: rtl/fx_slave_fifo.sv
//------------------------------------------------------------------------------
// fx_slave_fifo
// Single-clock local-to-host byte FIFO with sticky overflow flag.
// Push while full is dropped unless a pop is accepted in the same cycle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fx_slave_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  input  logic          ovf_clr_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic          ovf_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          w_full, w_empty, w_push_ok, w_pop_ok;

  assign w_empty   = (level_q == '0);
  assign w_full    = (level_q == (AW+1)'(DEPTH));
  assign w_pop_ok  = pop_i && !w_empty;
  // A pop frees the slot the simultaneous push needs, so a full FIFO accepts both
  assign w_push_ok = push_i && (!w_full || w_pop_ok);

  // Next-state for pointers, level and the sticky overflow flag (set beats clear)
  always_comb begin
    wptr_d  = w_push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = w_pop_ok  ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q;
    if (w_push_ok && !w_pop_ok) level_d = level_q + 1'b1;
    if (!w_push_ok && w_pop_ok) level_d = level_q - 1'b1;
    ovf_d   = (ovf_q && !ovf_clr_i) || (push_i && !w_push_ok);
  end

  // Control state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset; contents are only visible through the pointers
  always_ff @(posedge clk_i) begin
    if (w_push_ok) mem_q[wptr_q] <= data_i;
  end

  assign rdata_o = w_empty ? '0 : mem_q[rptr_q];
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign level_o = level_q;
  assign ovf_o   = ovf_q;

endmodule : fx_slave_fifo

`default_nettype wire

// File: rtl/fx_slave_regs.sv
//------------------------------------------------------------------------------
// fx_slave_regs
// fx bus responder: config bank, ID/version, status, command pulses and an
// optional local-to-host FIFO, enabled by defining FX_SLAVE_FIFO_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fx_slave_regs
  import fx_pkg::*;
#(
  parameter logic [FX_DEV_W-1:0]  DEV_ID     = 6'h01,
  parameter logic [FX_DATA_W-1:0] VERSION    = 8'h10,
  parameter int                   FIFO_DEPTH = 16
) (
  input  logic                           clk_sys_i,
  input  logic                           rst_i,
  input  logic                           fx_wr_i,
  input  logic [FX_ADDR_W-1:0]           fx_waddr_i,
  input  logic [FX_DATA_W-1:0]           fx_data_i,
  input  logic                           fx_rd_i,
  input  logic [FX_ADDR_W-1:0]           fx_raddr_i,
  output logic [FX_DATA_W-1:0]           fx_q_o,
  output logic [FX_NUM_CFG*FX_DATA_W-1:0] cfg_regs_o,
  output logic [FX_DATA_W-1:0]           cmd_pulse_o,
  input  logic [FX_DATA_W-1:0]           in_data_i,
  input  logic                           in_vld_i,
  output logic                           irq_o
);

  logic [FX_NUM_CFG-1:0][FX_DATA_W-1:0] cfg_q, cfg_d;
  logic [FX_DATA_W-1:0] fx_q_q, fx_q_d;
  logic [FX_DATA_W-1:0] cmd_q, cmd_d;
  logic [FX_DATA_W-1:0] w_rd_data;
  logic [FX_DATA_W-1:0] w_stat_byte, w_lvl_byte, w_fifo_byte;
  logic [FX_REG_W-1:0]  w_wreg, w_rreg;
  logic                 w_wr_hit, w_rd_hit;

  assign w_wreg   = fx_waddr_i[FX_REG_W-1:0];
  assign w_rreg   = fx_raddr_i[FX_REG_W-1:0];
  assign w_wr_hit = fx_wr_i && (fx_waddr_i[FX_ADDR_W-1:FX_REG_W] == DEV_ID);
  assign w_rd_hit = fx_rd_i && (fx_raddr_i[FX_ADDR_W-1:FX_REG_W] == DEV_ID);

`ifdef FX_SLAVE_FIFO_EN
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [FX_DATA_W-1:0] w_fifo_rdata;
  logic [LVL_W-1:0]     w_level;
  logic [15:0]          w_level_ext;
  logic                 w_full, w_empty, w_ovf;

  fx_slave_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (FX_DATA_W)
  ) u_fifo (
    .clk_i     (clk_sys_i),
    .rst_i     (rst_i),
    .push_i    (in_vld_i),
    .data_i    (in_data_i),
    .pop_i     (w_rd_hit && (w_rreg == REG_FIFO)),
    .ovf_clr_i (w_wr_hit && (w_wreg == REG_STAT) && fx_data_i[STAT_OVF]),
    .rdata_o   (w_fifo_rdata),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .level_o   (w_level),
    .ovf_o     (w_ovf)
  );

  // Level register saturates so a 256-deep FIFO still fits in one byte
  assign w_level_ext = 16'(w_level);
  assign w_lvl_byte  = (w_level_ext > 16'd255) ? 8'hFF : w_level_ext[7:0];
  assign w_fifo_byte = w_fifo_rdata;
  assign w_stat_byte = {5'b00000, w_ovf, w_full, w_empty};
  assign irq_o       = !w_empty || w_ovf;
`else
  logic w_unused_fifo;

  assign w_unused_fifo = ^{in_data_i, in_vld_i, FIFO_DEPTH[0]};
  assign w_lvl_byte    = '0;
  assign w_fifo_byte   = '0;
  assign w_stat_byte   = '0;
  assign irq_o         = 1'b0;
`endif

  // Read mux; config bytes occupy offsets 0x0000-0x000F
  always_comb begin
    w_rd_data = '0;
    if (w_rreg[FX_REG_W-1:4] == REG_CFG0[FX_REG_W-1:4]) begin
      w_rd_data = cfg_q[w_rreg[3:0]];
    end else begin
      case (w_rreg)
        REG_ID:   w_rd_data = {{(FX_DATA_W-FX_DEV_W){1'b0}}, DEV_ID};
        REG_VER:  w_rd_data = VERSION;
        REG_STAT: w_rd_data = w_stat_byte;
        REG_LVL:  w_rd_data = w_lvl_byte;
        REG_FIFO: w_rd_data = w_fifo_byte;
        default:  w_rd_data = '0;
      endcase
    end
  end

  // Next-state for config bank, command pulse and read-data register
  always_comb begin
    cfg_d  = cfg_q;
    cmd_d  = '0;
    fx_q_d = w_rd_hit ? w_rd_data : '0;
    if (w_wr_hit && (w_wreg[FX_REG_W-1:4] == REG_CFG0[FX_REG_W-1:4])) begin
      cfg_d[w_wreg[3:0]] = fx_data_i;
    end
    if (w_wr_hit && (w_wreg == REG_PULSE)) begin
      cmd_d = fx_data_i;
    end
  end

  // Register bank state
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_q  <= '0;
      cmd_q  <= '0;
      fx_q_q <= '0;
    end else begin
      cfg_q  <= cfg_d;
      cmd_q  <= cmd_d;
      fx_q_q <= fx_q_d;
    end
  end

  assign cfg_regs_o  = cfg_q;
  assign cmd_pulse_o = cmd_q;
  assign fx_q_o      = fx_q_q;

endmodule : fx_slave_regs

`default_nettype wire

// File: tb/tb_fx_slave_regs.sv
//------------------------------------------------------------------------------
// tb_fx_slave_regs
// Directed self-checking bench for fx_slave_regs (FIFO_DEPTH = 16).
// Expected FIFO results follow FX_SLAVE_FIFO_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fx_slave_regs;

`ifdef FX_SLAVE_FIFO_EN
  localparam bit FIFO_ON = 1'b1;
`else
  localparam bit FIFO_ON = 1'b0;
`endif

  localparam logic [5:0] DEV = 6'h01;

  logic         clk_sys = 1'b0;
  logic         rst = 1'b1;
  logic         fx_wr = 1'b0;
  logic [21:0]  fx_waddr = '0;
  logic [7:0]   fx_data = '0;
  logic         fx_rd = 1'b0;
  logic [21:0]  fx_raddr = '0;
  logic [7:0]   fx_q;
  logic [127:0] cfg_regs;
  logic [7:0]   cmd_pulse;
  logic [7:0]   in_data = '0;
  logic         in_vld = 1'b0;
  logic         irq;

  int n_checks = 0;
  int n_fail   = 0;

  fx_slave_regs #(
    .DEV_ID     (DEV),
    .VERSION    (8'h10),
    .FIFO_DEPTH (16)
  ) dut (
    .clk_sys_i   (clk_sys),
    .rst_i       (rst),
    .fx_wr_i     (fx_wr),
    .fx_waddr_i  (fx_waddr),
    .fx_data_i   (fx_data),
    .fx_rd_i     (fx_rd),
    .fx_raddr_i  (fx_raddr),
    .fx_q_o      (fx_q),
    .cfg_regs_o  (cfg_regs),
    .cmd_pulse_o (cmd_pulse),
    .in_data_i   (in_data),
    .in_vld_i    (in_vld),
    .irq_o       (irq)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic fx_write(input logic [5:0] dev, input logic [15:0] r, input logic [7:0] d);
    fx_wr = 1'b1; fx_waddr = {dev, r}; fx_data = d;
    step();
    fx_wr = 1'b0;
  endtask

  task automatic fx_read(input logic [5:0] dev, input logic [15:0] r, output logic [7:0] d);
    fx_rd = 1'b1; fx_raddr = {dev, r};
    step();
    fx_rd = 1'b0;
    d = fx_q;
  endtask

  task automatic push(input logic [7:0] v);
    in_vld = 1'b1; in_data = v;
    step();
    in_vld = 1'b0;
  endtask

  logic [7:0] rd;

  initial begin
    // Reset
    repeat (3) @(posedge clk_sys);
    #1 rst = 1'b0;
    chk("rst_fx_q", fx_q, 0);
    chk("rst_cfg", cfg_regs, 0);
    chk("rst_pulse", cmd_pulse, 0);
    chk("rst_irq", irq, 0);

    // Config write/read with one-cycle read data
    fx_write(DEV, 16'h0003, 8'h5A);
    chk("cfg3_wr", cfg_regs, 128'h5A << 24);
    fx_read(DEV, 16'h0003, rd);
    chk("cfg3_rd", rd, 8'h5A);
    step();
    chk("cfg3_rd_drop", fx_q, 0);

    // Other device ignored
    fx_read(DEV + 6'd1, 16'h0010, rd);
    chk("other_dev_rd", rd, 0);
    fx_write(DEV + 6'd1, 16'h0003, 8'hFF);
    chk("other_dev_wr", cfg_regs, 128'h5A << 24);

    // ID and version
    fx_read(DEV, 16'h0010, rd);
    chk("id", rd, 8'h01);
    fx_read(DEV, 16'h0011, rd);
    chk("ver", rd, 8'h10);

    // Command pulses, including back-to-back
    fx_write(DEV, 16'h0015, 8'hA5);
    chk("pulse_a5", cmd_pulse, 8'hA5);
    step();
    chk("pulse_end", cmd_pulse, 0);
    fx_write(DEV, 16'h0015, 8'h01);
    chk("pulse_b2b_1", cmd_pulse, 8'h01);
    fx_write(DEV, 16'h0015, 8'h02);
    chk("pulse_b2b_2", cmd_pulse, 8'h02);
    fx_read(DEV, 16'h0015, rd);
    chk("pulse_rd", rd, 0);
    chk("pulse_after", cmd_pulse, 0);

    // Simultaneous read and write of the same register
    fx_wr = 1'b1; fx_waddr = {DEV, 16'h0003}; fx_data = 8'h77;
    fx_rd = 1'b1; fx_raddr = {DEV, 16'h0003};
    step();
    fx_wr = 1'b0; fx_rd = 1'b0;
    chk("rw_same_rd", fx_q, 8'h5A);
    chk("rw_same_wr", cfg_regs, 128'h77 << 24);

    // Unmapped offset aliasing a config index
    fx_write(DEV, 16'h0103, 8'hC3);
    chk("unmapped_wr", cfg_regs, 128'h77 << 24);
    fx_read(DEV, 16'h0103, rd);
    chk("unmapped_rd", rd, 0);
    fx_write(DEV, 16'h000F, 8'h9C);
    chk("cfg15_wr", cfg_regs[127:120], 8'h9C);

    // FIFO: three pushes then drain
    push(8'h11); push(8'h22); push(8'h33);
    chk("fifo3_irq", irq, FIFO_ON ? 1 : 0);
    fx_read(DEV, 16'h0013, rd);
    chk("fifo3_lvl", rd, FIFO_ON ? 8'h03 : 8'h00);
    fx_read(DEV, 16'h0014, rd);
    chk("pop_11", rd, FIFO_ON ? 8'h11 : 8'h00);
    fx_read(DEV, 16'h0014, rd);
    chk("pop_22", rd, FIFO_ON ? 8'h22 : 8'h00);
    fx_read(DEV, 16'h0014, rd);
    chk("pop_33", rd, FIFO_ON ? 8'h33 : 8'h00);
    fx_read(DEV, 16'h0014, rd);
    chk("pop_empty", rd, 0);
    fx_read(DEV, 16'h0012, rd);
    chk("stat_empty", rd, FIFO_ON ? 8'h01 : 8'h00);
    chk("irq_empty", irq, 0);

    // Overfill: 17 pushes into 16 entries
    for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
    fx_read(DEV, 16'h0012, rd);
    chk("stat_ovf", rd, FIFO_ON ? 8'h06 : 8'h00);
    fx_read(DEV, 16'h0013, rd);
    chk("lvl_full", rd, FIFO_ON ? 8'h10 : 8'h00);
    chk("irq_full", irq, FIFO_ON ? 1 : 0);
    fx_write(DEV, 16'h0012, 8'h04);
    fx_read(DEV, 16'h0012, rd);
    chk("stat_w1c", rd, FIFO_ON ? 8'h02 : 8'h00);

    // Push and pop together while full
    in_vld = 1'b1; in_data = 8'hEE;
    fx_rd = 1'b1; fx_raddr = {DEV, 16'h0014};
    step();
    in_vld = 1'b0; fx_rd = 1'b0;
    chk("full_pp_data", fx_q, FIFO_ON ? 8'h40 : 8'h00);
    fx_read(DEV, 16'h0013, rd);
    chk("full_pp_lvl", rd, FIFO_ON ? 8'h10 : 8'h00);
    fx_read(DEV, 16'h0012, rd);
    chk("full_pp_stat", rd, FIFO_ON ? 8'h02 : 8'h00);

    // Drain three to leave the FIFO partially full
    fx_read(DEV, 16'h0014, rd);
    chk("pop_41", rd, FIFO_ON ? 8'h41 : 8'h00);
    fx_read(DEV, 16'h0014, rd);
    fx_read(DEV, 16'h0014, rd);
    fx_read(DEV, 16'h0013, rd);
    chk("lvl_13", rd, FIFO_ON ? 8'h0D : 8'h00);
    fx_write(DEV, 16'h0000, 8'h33);
    chk("cfg0_wr", cfg_regs[7:0], 8'h33);

    // Asynchronous reset in the middle of a write, pulse and push
    step();
    fx_wr = 1'b1; fx_waddr = {DEV, 16'h0015}; fx_data = 8'h44;
    in_vld = 1'b1; in_data = 8'h55;
    fx_rd = 1'b1; fx_raddr = {DEV, 16'h0010};
    #2 rst = 1'b1;
    #1;
    chk("arst_cfg", cfg_regs, 0);
    chk("arst_irq", irq, 0);
    fx_wr = 1'b0; in_vld = 1'b0; fx_rd = 1'b0;
    step();
    chk("arst_fx_q", fx_q, 0);
    chk("arst_pulse", cmd_pulse, 0);
    rst = 1'b0;
    step();
    chk("post_rst_cfg", cfg_regs, 0);
    fx_read(DEV, 16'h0013, rd);
    chk("post_rst_lvl", rd, 0);
    fx_read(DEV, 16'h0012, rd);
    chk("post_rst_stat", rd, FIFO_ON ? 8'h01 : 8'h00);

    // Push and pop together while empty
    in_vld = 1'b1; in_data = 8'h99;
    fx_rd = 1'b1; fx_raddr = {DEV, 16'h0014};
    step();
    in_vld = 1'b0; fx_rd = 1'b0;
    chk("empty_pp_data", fx_q, 0);
    chk("empty_pp_irq", irq, FIFO_ON ? 1 : 0);
    fx_read(DEV, 16'h0013, rd);
    chk("empty_pp_lvl", rd, FIFO_ON ? 8'h01 : 8'h00);
    fx_read(DEV, 16'h0014, rd);
    chk("empty_pp_pop", rd, FIFO_ON ? 8'h99 : 8'h00);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fx_slave_regs

`default_nettype wire
